// File: rtl/periph_pkg.sv
// -----------------------------------------------------------------------------
// periph_pkg
// Shared types and constants for the core-to-peripheral bus bridge and the
// accumulator/counter peripheral it fronts.
//   state_e          bridge FSM states
//   PERIPH_BASE_DEF  default base of the 16-byte peripheral window
//   OFS_*            peripheral word offsets (p_addr_o values)
//   in_window()      address match on bits [31:4]
// -----------------------------------------------------------------------------
package periph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [31:0] PERIPH_BASE_DEF = 32'hFFFF_FF00;

    localparam logic [1:0] OFS_CLR    = 2'd0;
    localparam logic [1:0] OFS_ACC_WR = 2'd1;
    localparam logic [1:0] OFS_ACC_RD = 2'd2;
    localparam logic [1:0] OFS_CNT_RD = 2'd3;

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:4] == base[31:4];
    endfunction

endpackage

// File: rtl/periph_bridge_timer.sv
// -----------------------------------------------------------------------------
// periph_bridge_timer
// Saturating timeout counter for the bridge WAIT state. Counts enabled cycles
// from zero and holds at LIMIT-1; expired_o is high while the count sits there.
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   clr_i      in   synchronous clear (dominates en_i)
//   en_i       in   count enable
//   expired_o  out  count == LIMIT-1
// -----------------------------------------------------------------------------
module periph_bridge_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] TC = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TC)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TC);

endmodule

// File: rtl/periph_bus_bridge.sv
// -----------------------------------------------------------------------------
// periph_bus_bridge
// Bridges the core data-memory port to the accumulator/counter peripheral.
// A request hitting the 16-byte window stalls the core until the peripheral's
// periodic p_valid_i window; exactly one ce/we cycle is issued in that window,
// load data is captured, and the core is released the following cycle.
// Misaligned requests and a silent peripheral both end in a one-cycle error.
//
// State table
//   state | meaning
//   IDLE  | no access in flight; decode window, latch request
//   WAIT  | aligned access pending; issue in the p_valid_i cycle or time out
//   DONE  | access complete; core released, load data presented
//   ERR   | misaligned or timed out; core released with error pulse
//
// Ports
//   clk, reset                 clock, async active-high reset
//   core_req_i/we_i/addr_i/wdata_i   core request
//   core_hit_o                 request targets the peripheral window
//   core_stall_o               hold core pipeline
//   core_rdata_o, core_err_o   response (DONE/ERR cycle)
//   p_ce_o/we_o/addr_o/wdata_o peripheral access
//   p_rdata_i, p_valid_i       peripheral read data and access window
//   p_stall_o                  peripheral freeze, low only in the issue cycle
// -----------------------------------------------------------------------------
module periph_bus_bridge
    import periph_pkg::*;
#(
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF,
    parameter int          TIMEOUT     = 15,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_hit_o,
    output logic        core_stall_o,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    output logic        p_ce_o,
    output logic        p_we_o,
    output logic [1:0]  p_addr_o,
    output logic [31:0] p_wdata_o,
    input  logic [31:0] p_rdata_i,
    input  logic        p_valid_i,
    output logic        p_stall_o
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_expired;

    // Counts only WAIT cycles without a valid window; cleared everywhere else.
    periph_bridge_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q != ST_WAIT),
        .en_i      ((state_q == ST_WAIT) && !p_valid_i),
        .expired_o (tmo_expired)
    );

    assign core_hit_o = core_req_i && in_window(core_addr_i, PERIPH_BASE);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (core_hit_o) begin
                    we_d    = core_we_i;
                    addr_d  = core_addr_i[3:2];
                    wdata_d = core_wdata_i;
                    state_d = (core_addr_i[1:0] == 2'b00) ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                // A valid window in the timeout cycle still completes the access.
                if (p_valid_i) begin
                    rdata_d = we_q ? 32'h0 : p_rdata_i;
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 2'b00;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The issue cycle follows p_valid_i combinationally so the access lands
    // inside the peripheral's window rather than one cycle after it.
    assign p_ce_o    = (state_q == ST_WAIT) && p_valid_i;
    assign p_we_o    = p_ce_o && we_q;
    assign p_stall_o = !p_ce_o;
    assign p_addr_o  = addr_q;
    assign p_wdata_o = wdata_q;

    assign core_err_o = (state_q == ST_ERR);

    always_comb begin
        core_rdata_o = 32'h0;
        if (state_q == ST_DONE) begin
            core_rdata_o = rdata_q;
        end else if (state_q == ST_ERR) begin
            core_rdata_o = ERR_RDATA;
        end
    end

    // Reset must release the core even if an access was in flight.
    always_comb begin
        core_stall_o = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: core_stall_o = core_hit_o;
                ST_WAIT: core_stall_o = 1'b1;
                default: core_stall_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_bridge.sv
module tb_periph_bus_bridge;
    import periph_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int          TMO  = 15;
    localparam logic [31:0] ERRD = 32'h0000_0000;
    localparam int          PER  = 1000;          // vdelay code: periodic window, period 4
    localparam logic [31:0] OTHER_RD = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        core_req_i;
    logic        core_we_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic        core_hit_o;
    logic        core_stall_o;
    logic [31:0] core_rdata_o;
    logic        core_err_o;
    logic        p_ce_o;
    logic        p_we_o;
    logic [1:0]  p_addr_o;
    logic [31:0] p_wdata_o;
    logic [31:0] p_rdata_i;
    logic        p_valid_i;
    logic        p_stall_o;

    periph_bus_bridge #(
        .PERIPH_BASE (BASE),
        .TIMEOUT     (TMO),
        .ERR_RDATA   (ERRD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_hit_o   (core_hit_o),
        .core_stall_o (core_stall_o),
        .core_rdata_o (core_rdata_o),
        .core_err_o   (core_err_o),
        .p_ce_o       (p_ce_o),
        .p_we_o       (p_we_o),
        .p_addr_o     (p_addr_o),
        .p_wdata_o    (p_wdata_o),
        .p_rdata_i    (p_rdata_i),
        .p_valid_i    (p_valid_i),
        .p_stall_o    (p_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus peripheral: accumulator / counter ----------------
    logic [31:0] per_acc = 32'h0;
    logic [31:0] per_cnt = 32'h0;

    always @(posedge clk) begin
        if (p_ce_o && p_we_o) begin
            if (p_addr_o == OFS_CLR) begin
                per_acc <= 32'h0;
                per_cnt <= 32'h0;
            end else if (p_addr_o == OFS_ACC_WR) begin
                per_acc <= per_acc + p_wdata_o;
                per_cnt <= per_cnt + 32'd1;
            end
        end
    end

    assign p_rdata_i = (p_addr_o == OFS_ACC_RD) ? per_acc :
                       (p_addr_o == OFS_CNT_RD) ? per_cnt : OTHER_RD;

    // ---------------- reference model (transaction level) ----------------
    // phase: 0 idle, 1 awaiting window, 2 respond ok, 3 respond error
    int          m_phase = 0;
    int          m_waited;
    logic        m_we;
    logic [1:0]  m_ofs;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    logic [31:0] ref_acc = 32'h0;
    logic [31:0] ref_cnt = 32'h0;
    logic        exp_hit;

    function automatic logic [31:0] ref_read(input logic [1:0] ofs);
        if (ofs == 2'd2) return ref_acc;
        if (ofs == 2'd3) return ref_cnt;
        return OTHER_RD;
    endfunction

    always @(negedge clk) begin
        exp_hit = core_req_i && (core_addr_i[31:4] == BASE[31:4]);
        check1("m_hit", core_hit_o, exp_hit);
        if (reset) begin
            check1("m_rst_stall", core_stall_o, 1'b0);
            check1("m_rst_ce", p_ce_o, 1'b0);
            check1("m_rst_pstall", p_stall_o, 1'b1);
            check1("m_rst_err", core_err_o, 1'b0);
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin
                    check1("m_idle_stall", core_stall_o, exp_hit);
                    check1("m_idle_ce", p_ce_o, 1'b0);
                    check1("m_idle_pstall", p_stall_o, 1'b1);
                    check1("m_idle_err", core_err_o, 1'b0);
                    if (exp_hit) begin
                        m_we     = core_we_i;
                        m_ofs    = core_addr_i[3:2];
                        m_wd     = core_wdata_i;
                        m_waited = 0;
                        m_phase  = (core_addr_i[1:0] == 2'b00) ? 1 : 3;
                    end
                end
                1: begin
                    check1("m_wait_stall", core_stall_o, 1'b1);
                    check1("m_wait_ce", p_ce_o, p_valid_i);
                    check1("m_wait_we", p_we_o, p_valid_i && m_we);
                    check1("m_wait_pstall", p_stall_o, !p_valid_i);
                    check1("m_wait_err", core_err_o, 1'b0);
                    if (p_valid_i) begin
                        check32("m_issue_addr", {30'h0, p_addr_o}, {30'h0, m_ofs});
                        if (m_we) check32("m_issue_wdata", p_wdata_o, m_wd);
                        m_rd = m_we ? 32'h0 : ref_read(m_ofs);
                        if (m_we && m_ofs == 2'd0) begin
                            ref_acc = 32'h0;
                            ref_cnt = 32'h0;
                        end else if (m_we && m_ofs == 2'd1) begin
                            ref_acc = ref_acc + m_wd;
                            ref_cnt = ref_cnt + 32'd1;
                        end
                        m_phase = 2;
                    end else begin
                        m_waited++;
                        if (m_waited == TMO) m_phase = 3;
                    end
                end
                2: begin
                    check1("m_done_stall", core_stall_o, 1'b0);
                    check1("m_done_ce", p_ce_o, 1'b0);
                    check1("m_done_err", core_err_o, 1'b0);
                    check32("m_done_rdata", core_rdata_o, m_rd);
                    m_phase = 0;
                end
                default: begin
                    check1("m_err_stall", core_stall_o, 1'b0);
                    check1("m_err_ce", p_ce_o, 1'b0);
                    check1("m_err_err", core_err_o, 1'b1);
                    check32("m_err_rdata", core_rdata_o, ERRD);
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- transaction driver ----------------
    // Entered and left at posedge+1. vdelay: -1 never valid, PER periodic,
    // otherwise valid only in request cycle index vdelay.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int vdelay, output logic [31:0] rd, output logic err,
                        output int stalls, output int ces, output logic [1:0] ce_ofs,
                        output logic ce_we, output logic hit0);
        int  k;
        bit  done;
        k = 0; done = 0; stalls = 0; ces = 0;
        rd = 32'hX; err = 1'bX; ce_ofs = 2'bXX; ce_we = 1'bX; hit0 = 1'b0;
        core_req_i = 1'b1; core_we_i = we; core_addr_i = addr; core_wdata_i = wd;
        while (!done) begin
            if (vdelay == PER) p_valid_i = ((cyc % 4) == 3);
            else               p_valid_i = (vdelay >= 0) && (k == vdelay);
            @(negedge clk);
            if (k == 0) hit0 = core_hit_o;
            if (p_ce_o) begin
                ces++;
                ce_ofs = p_addr_o;
                ce_we  = p_we_o;
            end
            if (core_stall_o) stalls++;
            else begin
                done = 1;
                rd   = core_rdata_o;
                err  = core_err_o;
            end
            k++;
            if (!done && k > 40) begin
                check1("xfer_release_bound", 1'b0, 1'b1);
                done = 1;
            end
            @(posedge clk); #1;
        end
        core_req_i = 1'b0;
        p_valid_i  = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err, ce_we, hit0;
    logic [1:0]  ce_ofs;
    int          stalls, ces;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = BASE + 32'd8; core_wdata_i = 32'h0;
        p_valid_i = 1'b1;
        // reset state, with a window hit and valid present
        @(negedge clk);
        check1("rst_core_stall", core_stall_o, 1'b0);
        check1("rst_p_ce", p_ce_o, 1'b0);
        check1("rst_p_we", p_we_o, 1'b0);
        check1("rst_p_stall", p_stall_o, 1'b1);
        check1("rst_err", core_err_o, 1'b0);
        check32("rst_rdata", core_rdata_o, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; core_req_i = 1'b0; p_valid_i = 1'b0;
        @(posedge clk); #1;

        // 1: store 5 to BASE+4, valid 3rd cycle of request
        xfer(1'b1, BASE + 32'd4, 32'd5, 2, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t1_stalls", stalls, 32'd3);
        check32("t1_ces", ces, 32'd1);
        check32("t1_ce_ofs", {30'h0, ce_ofs}, 32'd1);
        check1("t1_ce_we", ce_we, 1'b1);
        check1("t1_err", err, 1'b0);
        check32("t1_store_rdata", rd, 32'h0);

        // clear accumulator
        xfer(1'b1, BASE + 32'd0, 32'd0, 1, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("clr_ces", ces, 32'd1);

        // 2: stores 3,4 then read acc / count with periodic window
        xfer(1'b1, BASE + 32'd4, 32'd3, PER, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t2_st3_ces", ces, 32'd1);
        check1("t2_st3_lat", stalls <= 5, 1'b1);
        xfer(1'b1, BASE + 32'd4, 32'd4, PER, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t2_st4_ces", ces, 32'd1);
        check1("t2_st4_lat", stalls <= 5, 1'b1);
        xfer(1'b0, BASE + 32'd8, 32'd0, PER, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t2_acc", rd, 32'd7);
        check32("t2_acc_ces", ces, 32'd1);
        check1("t2_acc_we", ce_we, 1'b0);
        xfer(1'b0, BASE + 32'd12, 32'd0, PER, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t2_cnt", rd, 32'd2);
        check32("t2_cnt_ces", ces, 32'd1);

        // 3: misaligned load
        xfer(1'b0, BASE + 32'd6, 32'd0, 0, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t3_stalls", stalls, 32'd1);
        check1("t3_err", err, 1'b1);
        check32("t3_rdata", rd, ERRD);
        check32("t3_ces", ces, 32'd0);
        xfer(1'b0, BASE + 32'd8, 32'd0, 1, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t3_acc_kept", rd, 32'd7);

        // 4: timeout, valid in last WAIT cycle, valid one cycle too late
        xfer(1'b0, BASE + 32'd12, 32'd0, -1, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t4_tmo_stalls", stalls, 32'd16);
        check1("t4_tmo_err", err, 1'b1);
        check32("t4_tmo_ces", ces, 32'd0);
        xfer(1'b0, BASE + 32'd8, 32'd0, 15, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t4_last_stalls", stalls, 32'd16);
        check1("t4_last_err", err, 1'b0);
        check32("t4_last_rdata", rd, 32'd7);
        check32("t4_last_ces", ces, 32'd1);
        xfer(1'b1, BASE + 32'd4, 32'd100, 16, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check1("t4_late_err", err, 1'b1);
        check32("t4_late_ces", ces, 32'd0);

        // 5: reset mid-WAIT
        core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = BASE + 32'd4; core_wdata_i = 32'd50;
        p_valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; p_valid_i = 1'b1;
        @(negedge clk);
        check1("t5_core_stall", core_stall_o, 1'b0);
        check1("t5_p_ce", p_ce_o, 1'b0);
        check1("t5_p_stall", p_stall_o, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0; core_req_i = 1'b0; p_valid_i = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, BASE + 32'd12, 32'd0, 2, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t5_cnt_after", rd, 32'd2);
        check32("t5_ces_after", ces, 32'd1);

        // 6: miss back-to-back with a hit
        xfer(1'b1, 32'h0000_1000, 32'd77, 0, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check1("t6_miss_hit", hit0, 1'b0);
        check32("t6_miss_stalls", stalls, 32'd0);
        check32("t6_miss_ces", ces, 32'd0);
        xfer(1'b1, BASE + 32'd4, 32'd9, PER, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check1("t6_hit_hit", hit0, 1'b1);
        check32("t6_hit_ces", ces, 32'd1);
        check1("t6_hit_err", err, 1'b0);
        xfer(1'b0, BASE + 32'd8, 32'd0, PER, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t6_acc", rd, 32'd16);
        xfer(1'b0, BASE + 32'd12, 32'd0, PER, rd, err, stalls, ces, ce_ofs, ce_we, hit0);
        check32("t6_cnt", rd, 32'd3);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
